// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Owns the PC. Issues single-outstanding word reads to instruction memory and presents
// {valid, instr, pc} in the IF/ID register for decode.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_req_o            request valid (held until accepted)
//   imem_addr_o           word address of the request (bits[1:0] always 0)
//   imem_ready_i          memory accepts the request this cycle
//   imem_rvalid_i         response strobe
//   imem_rdata_i          response instruction word
//   stall_i               decode cannot accept; IF/ID holds while it is valid
//   redirect_i            flush IF/ID and refetch from redirect_pc_i
//   redirect_pc_i         new PC (bits[1:0] forced to 0)
//   if_id_valid_o         IF/ID holds a real instruction
//   if_id_instr_o         instruction, NOP_INSTR when invalid
//   if_id_pc_o            PC of if_id_instr_o, 0 when invalid
module fetch_stage #(
    parameter int unsigned        XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]    NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o
);

    typedef enum logic [1:0] {StFetch, StWait, StKill} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            skid_valid_q;
    logic [XLEN-1:0] skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    logic            if_id_valid_q;
    logic [XLEN-1:0] if_id_instr_q;
    logic [XLEN-1:0] if_id_pc_q;

    logic            req;
    logic            accept;
    logic            resp;
    logic            hold;
    logic            outstanding;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic [XLEN-1:0] pc_inc;

    // A full skid blocks issue, so at most one response can ever be waiting behind IF/ID.
    assign req    = (state_q == StFetch) && !skid_valid_q && !rst_i;
    assign accept = req && imem_ready_i;
    // Only a response to a live request counts; KILL responses are dropped.
    assign resp   = (state_q == StWait) && imem_rvalid_i;
    assign hold   = stall_i && if_id_valid_q;

    // A request is still in flight after this cycle if one is accepted now, or if we are
    // waiting and its response does not arrive this cycle.
    assign outstanding = accept ||
                         (((state_q == StWait) || (state_q == StKill)) && !imem_rvalid_i);

    assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);
    assign pc_inc              = pc_q + XLEN'(4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
        end else if (redirect_i) begin
            state_q       <= outstanding ? StKill : StFetch;
            pc_q          <= redirect_pc_aligned;
            skid_valid_q  <= 1'b0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (accept) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid_i) begin
                        state_q <= StFetch;
                        pc_q    <= pc_inc;
                    end
                end
                StKill: begin
                    if (imem_rvalid_i) begin
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase

            // pc_q still names the outstanding request while in StWait.
            if (hold) begin
                if (resp) begin
                    skid_valid_q <= 1'b1;
                    skid_instr_q <= imem_rdata_i;
                    skid_pc_q    <= pc_q;
                end
            end else if (skid_valid_q) begin
                if_id_valid_q <= 1'b1;
                if_id_instr_q <= skid_instr_q;
                if_id_pc_q    <= skid_pc_q;
                skid_valid_q  <= resp;
                if (resp) begin
                    skid_instr_q <= imem_rdata_i;
                    skid_pc_q    <= pc_q;
                end
            end else if (resp) begin
                if_id_valid_q <= 1'b1;
                if_id_instr_q <= imem_rdata_i;
                if_id_pc_q    <= pc_q;
            end else begin
                if_id_valid_q <= 1'b0;
                if_id_instr_q <= NOP_INSTR;
                if_id_pc_q    <= '0;
            end
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = if_id_valid_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_pc_o    = if_id_pc_q;

`ifndef SYNTHESIS
    // A response to a request issued before reset may land in the first cycle after it.
    logic post_rst_q;

    always_ff @(posedge clk_i) begin
        post_rst_q <= rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !post_rst_q) begin
            assert (!imem_rvalid_i || (state_q != StFetch))
                else $error("imem response with no request outstanding");
            assert (redirect_i || hold || !skid_valid_q || !resp)
                else $error("skid drained while a response arrived");
            assert (if_id_pc_q[1:0] == 2'b00)
                else $error("IF/ID pc not word aligned");
        end
    end
`endif

endmodule
